// File: rtl/jtvigil_colmix_pkg.sv
// Shared constants for the Vigilante colour mixer: layer bases in palette
// index space, priority bank default and palette component codes.
package jtvigil_colmix_pkg;

  localparam logic [3:0] PRIO_BANK_DEF = 4'hC;

  localparam logic [8:0] SCR1_BASE = 9'h000;
  localparam logic [8:0] OBJ_BASE  = 9'h100;
  localparam logic [8:0] SCR2_BASE = 9'h180;

  localparam int         NUM_COMP    = 3;
  localparam logic [7:0] UNMAPPED_RD = 8'hFF;

  typedef enum logic [1:0] {
    COMP_R    = 2'd0,
    COMP_G    = 2'd1,
    COMP_B    = 2'd2,
    COMP_NONE = 2'd3
  } comp_e;

  typedef enum logic [1:0] {
    LAYER_NONE = 2'd0,
    LAYER_SCR1 = 2'd1,
    LAYER_OBJ  = 2'd2,
    LAYER_SCR2 = 2'd3
  } layer_e;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-clock block RAM: port 0 read/write, port 1 read-only, both with
// registered read data.
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 9
) (
  input  logic          clk0,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic          clk1,
  input  logic [aw-1:0] addr1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(1<<aw)-1];

  always_ff @(posedge clk0) begin
    if (we0) mem[addr0] <= data0;
    q0 <= mem[addr0];
  end

  always_ff @(posedge clk1) begin
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtvigil_colmix_prio.sv
// Combinational layer priority / transparency encoder producing the 9-bit
// palette index of the winning layer, or a black flag when nothing is drawn.
module jtvigil_prio
  import jtvigil_colmix_pkg::*;
#(
  parameter logic [3:0] PRIO_BANK = PRIO_BANK_DEF
) (
  input  logic [7:0] scr1_pxl,
  input  logic [6:0] scr2_pxl,
  input  logic [6:0] obj_pxl,
  input  logic [2:0] gfx_en,
  output logic [8:0] pal_idx,
  output logic       black
);

  logic   scr1_opaque;
  logic   scr1_high;
  logic   obj_opaque;
  logic   scr2_opaque;
  layer_e sel;

  assign scr1_opaque = gfx_en[0] && (scr1_pxl[3:0] != 4'd0);
  assign scr1_high   = scr1_pxl[7:4] >= PRIO_BANK;
  assign obj_opaque  = gfx_en[2] && (obj_pxl[3:0] != 4'd0);
  assign scr2_opaque = gfx_en[1];

  always_comb begin
    sel = LAYER_NONE;
    if (scr1_opaque && scr1_high) sel = LAYER_SCR1;
    else if (obj_opaque)          sel = LAYER_OBJ;
    else if (scr1_opaque)         sel = LAYER_SCR1;
    else if (scr2_opaque)         sel = LAYER_SCR2;
  end

  always_comb begin
    pal_idx = 9'd0;
    black   = 1'b0;
    case (sel)
      LAYER_SCR1: pal_idx = SCR1_BASE | {1'b0, scr1_pxl};
      LAYER_OBJ:  pal_idx = OBJ_BASE  | {2'b00, obj_pxl};
      LAYER_SCR2: pal_idx = SCR2_BASE | {2'b00, scr2_pxl};
      default:    black   = 1'b1;
    endcase
  end

endmodule

// File: rtl/jtvigil_colmix.sv
// Final video stage: layer priority, palette RAM lookup and blanking-aligned
// 5-bit RGB output. CPU owns port A of the palette RAMs on clk_cpu.
module jtvigil_colmix
  import jtvigil_colmix_pkg::*;
#(
  parameter logic [3:0] PRIO_BANK = PRIO_BANK_DEF
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        clk_cpu,
  input  logic        pxl_cen,
  input  logic [10:0] main_addr,
  input  logic [7:0]  main_dout,
  output logic [7:0]  main_din,
  input  logic        main_rnw,
  input  logic        pal_cs,
  input  logic [7:0]  scr1_pxl,
  input  logic [6:0]  scr2_pxl,
  input  logic [6:0]  obj_pxl,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [2:0]  gfx_en,
  output logic [4:0]  red,
  output logic [4:0]  green,
  output logic [4:0]  blue,
  output logic        LHBL_dly,
  output logic        LVBL_dly
);

  logic [8:0] prio_idx;
  logic       prio_black;

  logic [8:0] idx_reg;
  logic       black_reg;
  logic       lhbl_reg;
  logic       lvbl_reg;
  comp_e      cpu_comp_reg;

  logic [7:0] cpu_q [NUM_COMP];
  logic [7:0] vid_q [NUM_COMP];
  logic       unused_bits;

  jtvigil_prio #(.PRIO_BANK(PRIO_BANK)) u_prio (
    .scr1_pxl (scr1_pxl),
    .scr2_pxl (scr2_pxl),
    .obj_pxl  (obj_pxl),
    .gfx_en   (gfx_en),
    .pal_idx  (prio_idx),
    .black    (prio_black)
  );

  // One RAM per component; component 3 has no RAM so its writes fall away.
  generate
    for (genvar gi = 0; gi < NUM_COMP; gi++) begin : g_pal
      logic we;
      assign we = pal_cs && !main_rnw && (main_addr[10:9] == 2'(gi));

      jtframe_dual_ram #(.dw(8), .aw(9)) u_ram (
        .clk0  (clk_cpu),
        .data0 (main_dout),
        .addr0 (main_addr[8:0]),
        .we0   (we),
        .q0    (cpu_q[gi]),
        .clk1  (clk),
        .addr1 (idx_reg),
        .q1    (vid_q[gi])
      );
    end
  endgenerate

  // Component select follows the RAM read latency so main_din lines up.
  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) cpu_comp_reg <= COMP_R;
    else     cpu_comp_reg <= comp_e'(main_addr[10:9]);
  end

  always_comb begin
    main_din = UNMAPPED_RD;
    case (cpu_comp_reg)
      COMP_R:  main_din = cpu_q[0];
      COMP_G:  main_din = cpu_q[1];
      COMP_B:  main_din = cpu_q[2];
      default: main_din = UNMAPPED_RD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= 9'd0;
      black_reg <= 1'b1;
      lhbl_reg  <= 1'b0;
      lvbl_reg  <= 1'b0;
    end else if (pxl_cen) begin
      idx_reg   <= prio_idx;
      black_reg <= prio_black;
      lhbl_reg  <= LHBL;
      lvbl_reg  <= LVBL;
    end
  end

  // Stage-0 blanking becomes LHBL_dly/LVBL_dly on this same edge, so the
  // colour is masked by exactly the blanking it is presented with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red      <= 5'd0;
      green    <= 5'd0;
      blue     <= 5'd0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      if (black_reg || !lhbl_reg || !lvbl_reg) begin
        red   <= 5'd0;
        green <= 5'd0;
        blue  <= 5'd0;
      end else begin
        red   <= vid_q[0][4:0];
        green <= vid_q[1][4:0];
        blue  <= vid_q[2][4:0];
      end
      LHBL_dly <= lhbl_reg;
      LVBL_dly <= lvbl_reg;
    end
  end

  assign unused_bits = ^{vid_q[0][7:5], vid_q[1][7:5], vid_q[2][7:5]};

endmodule

// File: doc/jtvigil_colmix.md
# jtvigil_colmix

Final video stage: merges scroll layer 1, scroll layer 2 and object pixels by priority, looks the result up in a CPU-writable palette RAM and drives 5-bit RGB with aligned blanking. It sits after the scroll-1 tilemap, scroll-2 and object generators and feeds the video output/scaler.

## Interface
Parameters
- PRIO_BANK, 4'hC: scroll-1 palettes >= this value are drawn over objects.

Ports
- rst  in  1  asynchronous, active-high reset
- clk  in  1  video clock
- clk_cpu  in  1  CPU clock, palette RAM port A
- pxl_cen  in  1  pixel clock enable
- main_addr  in  11  CPU palette address
- main_dout  in  8  CPU write data
- main_din  out  8  CPU read data
- main_rnw  in  1  1 = read
- pal_cs  in  1  palette chip select
- scr1_pxl  in  8  {palette[3:0], colour[3:0]}
- scr2_pxl  in  7  background colour index
- obj_pxl  in  7  {palette[2:0], colour[3:0]}
- LHBL, LVBL  in  1  blanking, active low
- gfx_en  in  3  layer enable: bit0 scr1, bit1 scr2, bit2 obj
- red, green, blue  out  5  pixel colour
- LHBL_dly, LVBL_dly  out  1  blanking aligned to RGB

## Operation
- Palette RAM: 2 KB CPU view. main_addr[10:9] selects component (0 R, 1 G, 2 B, 3 unmapped), main_addr[8:0] the colour index. Only bits [4:0] of each byte drive video; all 8 bits store and read back.
- Write when pal_cs & ~main_rnw, on clk_cpu. Writes to component 3 are ignored; reads of component 3 return 8'hFF. main_din valid one clk_cpu after address.
- Colour index (9 bits): scr1 -> {1'b0, scr1_pxl}; obj -> {2'b10, obj_pxl}; scr2 -> {2'b11, scr2_pxl}.
- Transparency: scr1 when scr1_pxl[3:0]==0 or gfx_en[0]==0; obj when obj_pxl[3:0]==0 or gfx_en[2]==0. scr2 always opaque unless gfx_en[1]==0.
- Priority, highest first: scr1 opaque with palette >= PRIO_BANK; obj opaque; scr1 opaque; scr2 enabled; else black (RGB forced 0, no RAM lookup used).
- Output: RGB = 0 whenever delayed LHBL or LVBL is low.

## Timing
- Reset: red/green/blue = 0, LHBL_dly = LVBL_dly = 0, pipeline index = 0, black flag = 1. Palette contents not reset.
- Stage 0 (pxl_cen N): register selected index, black flag, LHBL, LVBL.
- Stage 1: RAM port B read on clk from registered index; q valid next clk; pxl_cen spacing >= 2 clk required.
- Stage 2 (pxl_cen N+1): register RGB and blanking outputs. Total latency: 2 pxl_cen from input pixel to RGB; LHBL_dly/LVBL_dly delayed identically.
- Simultaneous CPU write and video read of same index: video sees old or new value, never a mix of components from different writes within one component byte.
- Pipeline registers advance only on pxl_cen; without pxl_cen outputs hold.
- Reset mid-frame: outputs go to reset values immediately (async); first valid pixel 2 pxl_cen after release.

## Structure
- Shared package/header: PRIO_BANK default, layer base indices (9'h000, 9'h100, 9'h180), component codes.
- Three jtframe_dual_ram instances (aw=9), one per component; port A clk_cpu, port B clk.
- One natural sub-module: jtvigil_prio — combinational priority/transparency encoder producing 9-bit index plus black flag.

## Test plan
- CPU writes 0x1F to 0x005, 0x10 to 0x105, 0x03 to 0x205; read back each -> main_din 0x1F, 0x10, 0x03; read 0x605 -> 0xFF.
- scr1_pxl=0x05, obj=0, scr2=0x00, blanking high -> two pxl_cen later RGB = 1F/10/03.
- obj_pxl=0x12 opaque, scr1_pxl=0x35 -> obj index 0x112 wins; scr1_pxl=0xC5 -> scr1 index 0x0C5 wins.
- scr1_pxl=0x30, obj_pxl=0x00, scr2_pxl=0x7F -> index 0x1FF output; gfx_en=3'b101 with same input -> RGB 0.
- LHBL low for one pixel with palette non-zero -> RGB 0 and LHBL_dly low exactly 2 pxl_cen later, one pixel wide.
- Assert rst mid-line -> RGB and blanking outputs 0 immediately; after release valid colour after 2 pxl_cen.
